// File: rtl/gpu_vram_arbiter.sv
// VRAM port arbiter: GPU pixel fetches always win. CPU writes queue in a small FIFO
// that drains only outside the visible region. Also generates a vblank-start pulse.
module gpu_vram_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hvisible,
    input  logic              vvisible,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_rdata,
    output logic              fetch_rvalid,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              vblank_start,
    output logic [CNT_W-1:0]  fifo_count
);

    typedef enum logic [1:0] {
        S_ACTIVE = 2'd0,
        S_HBLANK = 2'd1,
        S_VBLANK = 2'd2
    } region_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    region_t          state;
    wr_entry_t        fifo_mem [FIFO_DEPTH];
    wr_entry_t        head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [1:0]       rv;
    logic             prev_vv;
    logic             push;
    logic             rd_grant;
    logic             wr_grant;

    // Ready comes from the registered count only, so a pop cannot make room in the same cycle.
    assign cpu_ready    = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign push         = cpu_valid && cpu_ready;
    assign head         = fifo_mem[rd_ptr];
    assign rd_grant     = fetch_req;
    assign wr_grant     = !fetch_req && (state != S_ACTIVE) && (fifo_count != '0);
    assign fetch_rdata  = mem_rdata;
    assign fetch_rvalid = rv[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_VBLANK;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_wdata    <= '0;
            rv           <= '0;
            prev_vv      <= 1'b0;
            vblank_start <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
        end else begin
            // Grant above uses this register's old value, so the region lags the inputs by one cycle.
            if (hvisible && vvisible)
                state <= S_ACTIVE;
            else if (!vvisible)
                state <= S_VBLANK;
            else
                state <= S_HBLANK;

            if (rd_grant) begin
                mem_addr <= fetch_addr;
                mem_we   <= 1'b0;
            end else if (wr_grant) begin
                mem_addr  <= head.addr;
                mem_wdata <= head.data;
                mem_we    <= 1'b1;
            end else begin
                mem_we <= 1'b0;
            end

            rv           <= {rv[0], rd_grant};
            prev_vv      <= vvisible;
            vblank_start <= prev_vv && !vvisible;

            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (wr_grant)
                rd_ptr <= rd_ptr + PTR_W'(1);

            case ({push, wr_grant})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= '{addr: cpu_addr, data: cpu_wdata};
    end

endmodule

// File: tb/tb_gpu_vram_arbiter.sv
// Directed bench for gpu_vram_arbiter. The VRAM model returns addr[7:0] one cycle
// after mem_addr.
module tb_gpu_vram_arbiter;

    logic        clk;
    logic        rst;
    logic        hvisible;
    logic        vvisible;
    logic        fetch_req;
    logic [11:0] fetch_addr;
    logic [7:0]  fetch_rdata;
    logic        fetch_rvalid;
    logic        cpu_valid;
    logic        cpu_ready;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        vblank_start;
    logic [2:0]  fifo_count;

    int n_cmp = 0;
    int n_err = 0;
    int drain_cnt [5] = '{3, 3, 2, 1, 0};
    logic accepted;

    gpu_vram_arbiter #(.ADDR_W(12), .DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .hvisible     (hvisible),
        .vvisible     (vvisible),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_rdata  (fetch_rdata),
        .fetch_rvalid (fetch_rvalid),
        .cpu_valid    (cpu_valid),
        .cpu_ready    (cpu_ready),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .vblank_start (vblank_start),
        .fifo_count   (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM preloaded with data = addr[7:0]; the reads below never touch written locations.
    always @(posedge clk) mem_rdata <= mem_addr[7:0];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; hvisible = 1'b0; vvisible = 1'b0;
        fetch_req = 1'b0; fetch_addr = '0;
        cpu_valid = 1'b1; cpu_addr = 12'h123; cpu_wdata = 8'hAB;

        // Reset held 3 cycles with cpu_valid high: nothing may be pushed
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_count", fifo_count, 0);
            chk("rst_we", mem_we, 0);
        end
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rvalid", fetch_rvalid, 0);
        chk("rst_vbs", vblank_start, 0);
        chk("rst_ready", cpu_ready, 1);
        rst = 1'b0; cpu_valid = 1'b0;
        tick();
        chk("post_rst_ready", cpu_ready, 1);
        chk("post_rst_count", fifo_count, 0);

        // Fetch latency in the active region
        hvisible = 1'b1; vvisible = 1'b1;
        tick();
        chk("active_vbs", vblank_start, 0);
        for (int j = 0; j < 8; j++) begin
            fetch_req  = (j < 4);
            fetch_addr = 12'(16 + j);
            tick();
            chk("fetch_rvalid", fetch_rvalid, (j >= 1 && j <= 4));
            if (j >= 1 && j <= 4) chk("fetch_rdata", fetch_rdata, 16 + j - 1);
            chk("fetch_addr", mem_addr, (j < 4) ? 16 + j : 19);
            chk("fetch_we", mem_we, 0);
        end

        // Active-region hold: 5 pushes, 4 accepted, no writes
        fetch_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cpu_valid = 1'b1; cpu_addr = 12'(12'h200 + k); cpu_wdata = 8'(8'hA0 + k);
            tick();
            chk("hold_count", fifo_count, (k < 4) ? k + 1 : 4);
            chk("hold_we", mem_we, 0);
        end
        chk("hold_ready", cpu_ready, 0);
        tick();
        chk("hold_count2", fifo_count, 4);
        chk("hold_we2", mem_we, 0);

        // Enter hblank: first edge still sees the active state
        hvisible = 1'b0;
        tick();
        chk("hb_lag_we", mem_we, 0);
        chk("hb_lag_count", fifo_count, 4);
        chk("hb_lag_ready", cpu_ready, 0);
        for (int k = 0; k < 5; k++) begin
            accepted = cpu_valid && cpu_ready;
            tick();
            if (accepted) cpu_valid = 1'b0;
            chk("drain_we", mem_we, 1);
            chk("drain_addr", mem_addr, 12'h200 + k);
            chk("drain_data", mem_wdata, 8'hA0 + k);
            chk("drain_count", fifo_count, drain_cnt[k]);
        end
        chk("fifth_taken", cpu_valid, 0);
        tick();
        chk("drain_idle_we", mem_we, 0);
        chk("drain_hold_addr", mem_addr, 12'h204);
        chk("drain_hold_data", mem_wdata, 8'hA4);

        // vvisible falls: one-cycle vblank_start pulse
        vvisible = 1'b0;
        tick();
        chk("vbs_pulse", vblank_start, 1);
        tick();
        chk("vbs_clear", vblank_start, 0);

        // Priority in vblank: reads block the 2 queued writes
        fetch_req = 1'b1; fetch_addr = 12'h020;
        cpu_valid = 1'b1; cpu_addr = 12'h300; cpu_wdata = 8'hB0;
        tick();
        chk("pri_count1", fifo_count, 1);
        chk("pri_we1", mem_we, 0);
        chk("pri_addr1", mem_addr, 12'h020);
        fetch_addr = 12'h021; cpu_addr = 12'h301; cpu_wdata = 8'hB1;
        tick();
        chk("pri_count2", fifo_count, 2);
        chk("pri_we2", mem_we, 0);
        cpu_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fetch_addr = 12'(12'h030 + i);
            tick();
            chk("pri_rd_we", mem_we, 0);
            chk("pri_rd_addr", mem_addr, 12'h030 + i);
            chk("pri_rd_count", fifo_count, 2);
        end
        fetch_req = 1'b0;
        tick();
        chk("pri_w0_we", mem_we, 1);
        chk("pri_w0_addr", mem_addr, 12'h300);
        chk("pri_w0_data", mem_wdata, 8'hB0);
        chk("pri_w0_count", fifo_count, 1);
        chk("pri_last_rvalid", fetch_rvalid, 1);
        chk("pri_last_rdata", fetch_rdata, 8'h32);
        tick();
        chk("pri_w1_we", mem_we, 1);
        chk("pri_w1_addr", mem_addr, 12'h301);
        chk("pri_w1_data", mem_wdata, 8'hB1);
        chk("pri_w1_count", fifo_count, 0);
        chk("pri_w1_rvalid", fetch_rvalid, 0);
        tick();
        chk("pri_idle_we", mem_we, 0);

        // Hblank, count held at 1 by simultaneous push and pop
        vvisible = 1'b1; hvisible = 1'b0;
        fetch_req = 1'b1; fetch_addr = 12'h040;
        cpu_valid = 1'b1; cpu_addr = 12'h400; cpu_wdata = 8'hC0;
        tick();
        chk("pp_count0", fifo_count, 1);
        chk("pp_we0", mem_we, 0);
        chk("pp_vbs0", vblank_start, 0);
        fetch_req = 1'b0;
        for (int k = 1; k < 4; k++) begin
            cpu_addr = 12'(12'h400 + k); cpu_wdata = 8'(8'hC0 + k);
            tick();
            chk("pp_count", fifo_count, 1);
            chk("pp_we", mem_we, 1);
            chk("pp_addr", mem_addr, 12'h400 + k - 1);
            chk("pp_data", mem_wdata, 8'hC0 + k - 1);
        end
        cpu_valid = 1'b0;
        tick();
        chk("pp_last_addr", mem_addr, 12'h403);
        chk("pp_last_data", mem_wdata, 8'hC3);
        chk("pp_last_count", fifo_count, 0);
        tick();
        chk("pp_idle_we", mem_we, 0);
        vvisible = 1'b0;
        tick();
        chk("vbs2_pulse", vblank_start, 1);
        tick();
        chk("vbs2_clear", vblank_start, 0);

        // Reset with 3 writes queued and reads in flight
        fetch_req = 1'b1; cpu_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_addr = 12'(12'h050 + i);
            cpu_addr = 12'(12'h500 + i); cpu_wdata = 8'(8'hD0 + i);
            tick();
            chk("mid_count", fifo_count, i + 1);
            chk("mid_we", mem_we, 0);
        end
        chk("mid_rvalid", fetch_rvalid, 1);
        fetch_req = 1'b0; cpu_valid = 1'b0; rst = 1'b1;
        tick();
        chk("mrst_we", mem_we, 0);
        chk("mrst_rvalid", fetch_rvalid, 0);
        chk("mrst_count", fifo_count, 0);
        chk("mrst_ready", cpu_ready, 1);
        chk("mrst_addr", mem_addr, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("after_rst_we", mem_we, 0);
            chk("after_rst_count", fifo_count, 0);
            chk("after_rst_rvalid", fetch_rvalid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
